// File: rtl/multibyte_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multibyte_add_ctrl_if
// Purpose  : Request/result bundle for the multi-byte add sequencer.
//            The master issues start/operands, the slave returns
//            busy/done and the completed sum/overflow.
// Revision : 1.0 - initial release
// ============================================================================
interface multibyte_add_ctrl_if #(
  parameter int NUM_BYTES = 4
);
  logic                   start;
  logic [8*NUM_BYTES-1:0] a;
  logic [8*NUM_BYTES-1:0] b;
  logic                   carry_in;
  logic                   busy;
  logic                   done;
  logic [8*NUM_BYTES-1:0] sum;
  logic                   overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );
endinterface
`default_nettype wire

// File: rtl/multibyte_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_8bit / multibyte_add_ctrl
// Purpose  : Adds two NUM_BYTES-wide operands with one shared 8-bit adder,
//            one byte per clock, LSB first, carry chained through a
//            register. Start/busy/done handshake toward the requester.
// Revision : 1.0 - initial release
// ============================================================================

// Plain combinational byte adder; overflow is the carry out of bit 7.
module adder_8bit (
  input  wire logic [7:0] a,
  input  wire logic [7:0] b,
  input  wire logic       carry_in,
  output logic      [7:0] sum,
  output logic            overflow
);
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
endmodule

module multibyte_add_ctrl #(
  parameter int NUM_BYTES = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  multibyte_add_ctrl_if.slave  bus
);

  localparam int c_W     = 8 * NUM_BYTES;
  localparam int c_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BYTES - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_ADD  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [c_IDX_W-1:0] idx_q,   idx_d;
  logic [c_W-1:0]     a_q,     a_d;
  logic [c_W-1:0]     b_q,     b_d;
  logic               carry_q, carry_d;
  logic [c_W-1:0]     part_q,  part_d;
  logic [c_W-1:0]     sum_q,   sum_d;
  logic               ovf_q,   ovf_d;

  logic [7:0]     w_a_bytes [NUM_BYTES];
  logic [7:0]     w_b_bytes [NUM_BYTES];
  logic [7:0]     w_add_sum;
  logic           w_add_carry;
  logic [c_W-1:0] w_part_next;
  logic           w_ready;

  // Slice the captured operands into bytes and build the partial result
  // with the current byte replaced by the adder output.
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
    assign w_a_bytes[i] = a_q[8*i +: 8];
    assign w_b_bytes[i] = b_q[8*i +: 8];
    assign w_part_next[8*i +: 8] =
      (idx_q == c_IDX_W'(i)) ? w_add_sum : part_q[8*i +: 8];
  end

  adder_8bit u_adder (
    .a        (w_a_bytes[idx_q]),
    .b        (w_b_bytes[idx_q]),
    .carry_in (carry_q),
    .sum      (w_add_sum),
    .overflow (w_add_carry)
  );

  // A new request may be taken while idle or in the one-cycle done state.
  assign w_ready = (state_q == c_S_IDLE) || (state_q == c_S_DONE);

  // Next-state logic: walk the bytes in ADD, publish the result on the last one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    part_d  = part_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      c_S_IDLE: begin
      end
      c_S_ADD: begin
        part_d  = w_part_next;
        carry_d = w_add_carry;
        idx_d   = idx_q + c_IDX_W'(1);
        if (idx_q == c_LAST_IDX) begin
          sum_d   = w_part_next;
          ovf_d   = w_add_carry;
          idx_d   = '0;
          state_d = c_S_DONE;
        end
      end
      c_S_DONE: begin
        state_d = c_S_IDLE;
      end
      default: begin
        state_d = c_S_IDLE;
      end
    endcase

    // Accepting a request overrides the DONE->IDLE return (back-to-back ops).
    if (w_ready && bus.start) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.carry_in;
      idx_d   = '0;
      state_d = c_S_ADD;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == c_S_ADD);
  assign bus.done     = (state_q == c_S_DONE);
  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multibyte_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multibyte_add_ctrl
// Purpose  : Self-checking bench for multibyte_add_ctrl (NUM_BYTES=4):
//            directed scenarios plus random operands against an
//            arithmetic reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multibyte_add_ctrl;

  localparam int c_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multibyte_add_ctrl_if #(.NUM_BYTES(c_N)) bus ();

  multibyte_add_ctrl #(.NUM_BYTES(c_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic        s_rst   = 1'b1;
  logic        s_start = 1'b0;
  logic [31:0] s_a     = '0;
  logic [31:0] s_b     = '0;
  logic        s_cin   = 1'b0;

  always @(posedge clk) begin
    s_rst   <= rst;
    s_start <= bus.start;
    s_a     <= bus.a;
    s_b     <= bus.b;
    s_cin   <= bus.carry_in;
  end

  // Reference model: an accepted request yields a+b+cin after c_N cycles.
  int          m_cnt  = 0;
  logic [32:0] m_pend = '0;
  logic [31:0] m_sum  = '0;
  logic        m_ovf  = 1'b0;
  logic        m_done = 1'b0;

  initial begin
    bit ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (s_rst) begin
        m_cnt  = 0;
        m_done = 1'b0;
        m_sum  = '0;
        m_ovf  = 1'b0;
      end else begin
        ready  = (m_cnt == 0);
        m_done = 1'b0;
        if (m_cnt != 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            {m_ovf, m_sum} = m_pend;
            m_done = 1'b1;
          end
        end
        if (ready && s_start) begin
          m_pend = {1'b0, s_a} + {1'b0, s_b} + {32'd0, s_cin};
          m_cnt  = c_N;
        end
      end
      check("busy",     64'(bus.busy),     64'(m_cnt != 0));
      check("done",     64'(bus.done),     64'(m_done));
      check("sum",      64'(bus.sum),      64'(m_sum));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
    end
  end

  // Issue one request from an idle DUT and wait for its done pulse.
  // Operand inputs are scrambled after capture, and stray start pulses
  // are thrown in early in the busy window.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       output logic [32:0] res, output int lat);
    bit got;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.carry_in = tc;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.carry_in = 1'($urandom_range(0, 1));
        bus.start    = (lat < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    bus.start = 1'b0;
    check("done_timeout", 64'(got), 64'd1);
    res = {bus.overflow, bus.sum};
  endtask

  task automatic wait_done(input string name, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check(name, 64'(got), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] res;
    logic [31:0] ra, rb;
    logic        rc;
    int          lat;
    int          ndone;

    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;

    // 1: reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy),     64'd0);
    check("rst_done", 64'(bus.done),     64'd0);
    check("rst_sum",  64'(bus.sum),      64'h0);
    check("rst_ovf",  64'(bus.overflow), 64'd0);
    rst = 1'b0;

    // 2: simple carry into byte 1, latency
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, res, lat);
    check("t2_res", 64'(res), 64'h0_0000_0100);
    check("t2_lat", 64'(lat), 64'd4);

    // 3: carry ripples through every byte
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, res, lat);
    check("t3_res", 64'(res), 64'h1_0000_0000);

    // 4: start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    res   = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        ndone++;
        res = {bus.overflow, bus.sum};
      end
      @(negedge clk);
    end
    check("t4_ndone", 64'(ndone), 64'd1);
    check("t4_res",   64'(res),   64'h0_2345_6789);

    // 5: reset in the middle of an addition
    bus.start = 1'b1; bus.a = 32'h5; bus.b = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_done", 64'(bus.done), 64'd0);
    check("t5_sum",  64'(bus.sum),  64'h0);
    rst = 1'b0;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, res, lat);
    check("t5_res", 64'(res), 64'h1_0000_0000);

    // 6: start held through DONE gives a back-to-back operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h7; bus.b = 32'h9; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.a = 32'h1; bus.b = 32'h2;
    wait_done("t6_done1", lat);
    check("t6_res1", 64'({bus.overflow, bus.sum}), 64'h10);
    @(negedge clk);
    check("t6_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    wait_done("t6_done2", lat);
    check("t6_lat",  64'(lat), 64'd4);
    check("t6_res2", 64'({bus.overflow, bus.sum}), 64'h3);

    // Random operands
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'hFFFF_FFFF - rb;
      end
      do_op(ra, rb, rc, res, lat);
      check("rand_res", 64'(res), 64'({1'b0, ra} + {1'b0, rb} + {32'd0, rc}));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
